qtr_scan_sched: RTL

//  Round-robin scan scheduler for a bank of NGRP Pololu QTR-RC quad sensors sharing one emitter (LEDON) line.

---
 rtl/qtr_scan_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/qtr_scan_sched.sv
// Round-robin scan scheduler for a bank of QTR-RC quad reflectance sensors sharing one emitter.
// Each poll tick walks every enabled group through emit, charge and sense, then offers its result.
module qtr_scan_sched #(
  parameter int unsigned NGRP = 4,
  parameter int unsigned GW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m10clk_i,
  input  logic              u10clk_i,
  input  logic [3:0]        cfg_period_i,
  input  logic [7:0]        cfg_sens_i,
  input  logic [NGRP-1:0]   grp_en_i,
  input  logic [4*NGRP-1:0] q_in_i,
  output logic [NGRP-1:0]   q_oe_o,
  output logic              emit_on_o,
  output logic              res_valid_o,
  output logic [GW-1:0]     res_grp_o,
  output logic [3:0]        res_bits_o,
  input  logic              res_ack_i,
  output logic              busy_o,
  output logic              overrun_o,
  input  logic              ovr_clr_i
);

  typedef enum logic [2:0] {
    StIdle,
    StEmit,
    StCharge,
    StSense,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      pcnt_q, pcnt_d;
  logic [NGRP-1:0] mask_q, mask_d;
  logic [GW-1:0]   grp_q, grp_d;
  logic [7:0]      sens_q, sens_d;
  logic [7:0]      scnt_q, scnt_d;
  logic            valid_q, valid_d;
  logic [GW-1:0]   rgrp_q, rgrp_d;
  logic [3:0]      bits_q, bits_d;
  logic            ovr_q, ovr_d;

  logic            tick;
  logic [NGRP-1:0] grp_oh;
  logic [3:0]      grp_pins;
  logic [NGRP-1:0] mask_left;

  // Lowest-index set bit wins, so groups are served in ascending order.
  function automatic logic [GW-1:0] lowest_set(input logic [NGRP-1:0] m);
    logic [GW-1:0] idx;
    idx = '0;
    for (int i = int'(NGRP) - 1; i >= 0; i--) begin
      if (m[i]) idx = GW'(i);
    end
    return idx;
  endfunction

  // Poll timer: pcnt runs 1..cfg_period and fires a tick on the matching m10clk.
  always_comb begin
    pcnt_d = pcnt_q;
    tick   = 1'b0;
    if (m10clk_i) begin
      if (cfg_period_i == 4'd0) begin
        pcnt_d = 4'd1;
      end else if (pcnt_q == cfg_period_i) begin
        pcnt_d = 4'd1;
        tick   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + 4'd1;
      end
    end
  end

  // Decode the current group once; reused for the charge drive, pin select and mask clear.
  always_comb begin
    grp_oh   = '0;
    grp_pins = 4'h0;
    for (int i = 0; i < int'(NGRP); i++) begin
      if (grp_q == GW'(i)) begin
        grp_oh[i] = 1'b1;
        grp_pins  = q_in_i[4*i +: 4];
      end
    end
  end

  assign mask_left = mask_q & ~grp_oh;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    grp_d   = grp_q;
    sens_d  = sens_q;
    scnt_d  = scnt_q;
    valid_d = valid_q;
    rgrp_d  = rgrp_q;
    bits_d  = bits_q;
    ovr_d   = ovr_q;

    // A tick that lands mid-round is dropped; setting beats a coincident clear.
    if (tick && (state_q != StIdle)) begin
      ovr_d = 1'b1;
    end else if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (tick && (grp_en_i != '0)) begin
          mask_d  = grp_en_i;
          grp_d   = lowest_set(grp_en_i);
          sens_d  = (cfg_sens_i == 8'd0) ? 8'd1 : cfg_sens_i;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (u10clk_i) state_d = StCharge;
      end
      StCharge: begin
        if (u10clk_i) begin
          state_d = StSense;
          scnt_d  = 8'd1;
        end
      end
      StSense: begin
        if (u10clk_i) begin
          if (scnt_q == sens_q) begin
            bits_d  = grp_pins;
            rgrp_d  = grp_q;
            valid_d = 1'b1;
            state_d = StWait;
          end else begin
            scnt_d = scnt_q + 8'd1;
          end
        end
      end
      StWait: begin
        if (res_ack_i) begin
          valid_d = 1'b0;
          mask_d  = mask_left;
          if (mask_left != '0) begin
            grp_d   = lowest_set(mask_left);
            state_d = StEmit;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pcnt_q  <= 4'd1;
      mask_q  <= '0;
      grp_q   <= '0;
      sens_q  <= 8'd1;
      scnt_q  <= 8'd1;
      valid_q <= 1'b0;
      rgrp_q  <= '0;
      bits_q  <= 4'h0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      mask_q  <= mask_d;
      grp_q   <= grp_d;
      sens_q  <= sens_d;
      scnt_q  <= scnt_d;
      valid_q <= valid_d;
      rgrp_q  <= rgrp_d;
      bits_q  <= bits_d;
      ovr_q   <= ovr_d;
    end
  end

  // Outputs decode straight from state so the async reset clears them without a clock.
  always_comb begin
    emit_on_o = 1'b0;
    q_oe_o    = '0;
    unique case (state_q)
      StEmit:   emit_on_o = 1'b1;
      StCharge: begin
        emit_on_o = 1'b1;
        q_oe_o    = grp_oh;
      end
      StSense:  emit_on_o = 1'b1;
      default:  emit_on_o = 1'b0;
    endcase
  end

  assign busy_o      = (state_q != StIdle);
  assign res_valid_o = valid_q;
  assign res_grp_o   = rgrp_q;
  assign res_bits_o  = bits_q;
  assign overrun_o   = ovr_q;

endmodule
